// File: rtl/fir_mac_acc.sv
// fir_mac_acc: multiply-accumulate stage behind the FIR control FSM.
// An 11-deep sample delay line is multiplied tap by tap against the
// coefficient stream from SRAM. Each complete frame produces one
// registered output with a single-cycle valid pulse. A sample strobe that
// arrives mid-frame is deferred so that every tap of a frame sees the same
// snapshot of the delay line.
module fir_mac_acc #(
    parameter int DATA_W = 3,
    parameter int COEF_W = 16,
    parameter int TAPS   = 11,
    parameter int ACC_W  = 24
) (
    input  logic                     iClk12M,
    input  logic                     iRst,
    input  logic                     iEnSample600k,
    input  logic signed [DATA_W-1:0] iFirIn,
    input  logic                     iEnMAC,
    input  logic signed [COEF_W-1:0] iRdDtRam,
    output logic signed [ACC_W-1:0]  oMacOut,
    output logic                     oMacValid,
    output logic                     oOverrun
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_ACC  = 2'd1,
        P_WAIT = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  dly_q [TAPS];
    logic signed [DATA_W-1:0]  dly_d [TAPS];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [TAP_W-1:0]          tap_q, tap_d;
    logic                      shift_pend_q, shift_pend_d;
    logic signed [DATA_W-1:0]  pend_smp_q, pend_smp_d;
    logic signed [ACC_W-1:0]   mac_out_q, mac_out_d;
    logic                      mac_valid_q, mac_valid_d;
    logic                      overrun_q, overrun_d;

    logic signed [DATA_W-1:0]  dly_sel_s;
    logic signed [PROD_W-1:0]  coef_ext_s;
    logic signed [PROD_W-1:0]  dly_ext_s;
    logic signed [PROD_W-1:0]  prod_full_s;
    logic signed [ACC_W-1:0]   prod_s;

    // Select the delayed sample that matches the current tap.
    always_comb begin
        if (tap_q <= LAST_TAP) begin
            dly_sel_s = dly_q[tap_q];
        end else begin
            dly_sel_s = '0;
        end
    end

    // Full-width signed product, sign-extended into the accumulator width.
    assign coef_ext_s  = {{DATA_W{iRdDtRam[COEF_W-1]}}, iRdDtRam};
    assign dly_ext_s   = {{COEF_W{dly_sel_s[DATA_W-1]}}, dly_sel_s};
    assign prod_full_s = coef_ext_s * dly_ext_s;
    assign prod_s      = {{(ACC_W - PROD_W){prod_full_s[PROD_W-1]}}, prod_full_s};

    // Frame FSM, accumulator, and deferred sample-shift handling.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        tap_d        = tap_q;
        mac_out_d    = mac_out_q;
        mac_valid_d  = 1'b0;
        overrun_d    = 1'b0;
        shift_pend_d = shift_pend_q;
        pend_smp_d   = pend_smp_q;
        dly_d        = dly_q;

        case (state_q)
            P_IDLE: begin
                tap_d = '0;
                if (iEnMAC) begin
                    if (TAPS == 1) begin
                        mac_out_d   = prod_s;
                        mac_valid_d = 1'b1;
                        acc_d       = '0;
                        state_d     = P_WAIT;
                    end else begin
                        acc_d   = prod_s;
                        tap_d   = TAP_W'(1);
                        state_d = P_ACC;
                    end
                end else begin
                    state_d = P_IDLE;
                end
            end
            P_ACC: begin
                if (iEnMAC) begin
                    if (tap_q == LAST_TAP) begin
                        mac_out_d   = acc_q + prod_s;
                        mac_valid_d = 1'b1;
                        acc_d       = '0;
                        tap_d       = '0;
                        state_d     = P_WAIT;
                    end else begin
                        acc_d = acc_q + prod_s;
                        tap_d = tap_q + TAP_W'(1);
                    end
                end else begin
                    // A gap in the enable stream aborts the frame silently.
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = P_IDLE;
                end
            end
            P_WAIT: begin
                if (!iEnMAC) begin
                    state_d = P_IDLE;
                end else begin
                    state_d = P_WAIT;
                end
            end
            default: begin
                acc_d   = '0;
                tap_d   = '0;
                state_d = P_IDLE;
            end
        endcase

        if (state_q == P_ACC) begin
            // Freeze the delay line while a frame is in flight.
            if (iEnSample600k) begin
                if (!shift_pend_q) begin
                    shift_pend_d = 1'b1;
                    pend_smp_d   = iFirIn;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                shift_pend_d = shift_pend_q;
            end
        end else begin
            if (shift_pend_q) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    dly_d[k] = dly_q[k-1];
                end
                dly_d[0]     = pend_smp_q;
                // A strobe colliding with the deferred shift re-arms it.
                shift_pend_d = iEnSample600k;
                if (iEnSample600k) begin
                    pend_smp_d = iFirIn;
                end else begin
                    pend_smp_d = pend_smp_q;
                end
            end else if (iEnSample600k) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    dly_d[k] = dly_q[k-1];
                end
                dly_d[0] = iFirIn;
            end else begin
                shift_pend_d = 1'b0;
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            state_q      <= P_IDLE;
            acc_q        <= '0;
            tap_q        <= '0;
            shift_pend_q <= 1'b0;
            pend_smp_q   <= '0;
            mac_out_q    <= '0;
            mac_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            tap_q        <= tap_d;
            shift_pend_q <= shift_pend_d;
            pend_smp_q   <= pend_smp_d;
            mac_out_q    <= mac_out_d;
            mac_valid_q  <= mac_valid_d;
            overrun_q    <= overrun_d;
            for (int k = 0; k < TAPS; k++) begin
                dly_q[k] <= dly_d[k];
            end
        end
    end

    assign oMacOut   = mac_out_q;
    assign oMacValid = mac_valid_q;
    assign oOverrun  = overrun_q;

endmodule

// File: tb/tb_fir_mac_acc.sv
// Testbench for fir_mac_acc: directed frames checked against a frame-level
// model (dot product of the captured coefficients and the delay line) on
// every cycle, plus hand-computed literal results.
module tb_fir_mac_acc;

    localparam int TAPS = 11;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               strobe = 1'b0;
    logic signed [2:0]  fir_in = 3'sd0;
    logic               en = 1'b0;
    logic signed [15:0] coef = 16'sd0;
    logic signed [23:0] mac_out;
    logic               mac_valid;
    logic               overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcnt = 0;
    int ocnt = 0;
    int valid_cyc = 0;
    int start_cyc = 0;
    bit chk_en = 1'b0;
    int cf [TAPS];

    // Model state
    int m_dly [TAPS];
    int m_coef [TAPS];
    int m_state = 0;      // 0 idle, 1 accumulating, 2 waiting for enable low
    int m_tap = 0;
    bit m_pend = 1'b0;
    int m_pval = 0;
    int exp_out = 0;
    bit exp_valid = 1'b0;
    bit exp_ovr = 1'b0;

    fir_mac_acc dut (
        .iClk12M       (clk),
        .iRst          (rst),
        .iEnSample600k (strobe),
        .iFirIn        (fir_in),
        .iEnMAC        (en),
        .iRdDtRam      (coef),
        .oMacOut       (mac_out),
        .oMacValid     (mac_valid),
        .oOverrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic m_shift(input int v);
        for (int k = TAPS - 1; k > 0; k--) m_dly[k] = m_dly[k-1];
        m_dly[0] = v;
    endtask

    // Behavioural model, stepped at each clock edge or asynchronous reset.
    initial begin
        for (int k = 0; k < TAPS; k++) m_dly[k] = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int k = 0; k < TAPS; k++) m_dly[k] = 0;
                m_state = 0; m_tap = 0; m_pend = 0; m_pval = 0;
                exp_out = 0; exp_valid = 0; exp_ovr = 0;
            end else begin
                int old_state;
                old_state = m_state;
                exp_valid = 0;
                exp_ovr = 0;
                case (old_state)
                    0: if (en) begin
                        m_coef[0] = int'(coef);
                        m_tap = 1;
                        m_state = 1;
                    end
                    1: if (en) begin
                        m_coef[m_tap] = int'(coef);
                        if (m_tap == TAPS - 1) begin
                            int s;
                            s = 0;
                            for (int k = 0; k < TAPS; k++) s += m_coef[k] * m_dly[k];
                            exp_out = s;
                            exp_valid = 1;
                            m_tap = 0;
                            m_state = 2;
                        end else begin
                            m_tap++;
                        end
                    end else begin
                        m_tap = 0;
                        m_state = 0;
                    end
                    default: if (!en) m_state = 0;
                endcase
                if (old_state == 1) begin
                    if (strobe) begin
                        if (!m_pend) begin
                            m_pend = 1;
                            m_pval = int'(fir_in);
                        end else begin
                            exp_ovr = 1;
                        end
                    end
                end else if (m_pend) begin
                    m_shift(m_pval);
                    m_pend = strobe;
                    if (strobe) m_pval = int'(fir_in);
                end else if (strobe) begin
                    m_shift(int'(fir_in));
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("cyc_out", int'(mac_out), exp_out);
                chk("cyc_valid", int'(mac_valid), int'(exp_valid));
                chk("cyc_overrun", int'(overrun), int'(exp_ovr));
            end
            if (mac_valid) begin
                vcnt++;
                valid_cyc = cyc;
            end
            if (overrun) ocnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < TAPS; i++) begin
            strobe = 1'b1;
            fir_in = 3'(v);
            tick();
        end
        strobe = 1'b0;
        tick();
    endtask

    task automatic frame(input int n, input int s1, input int v1, input int s2, input int v2);
        start_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            coef = (i < TAPS) ? 16'(cf[i]) : 16'sd1000;
            strobe = (i == s1) || (i == s2);
            fir_in = (i == s1) ? 3'(v1) : 3'(v2);
            tick();
        end
        en = 1'b0;
        strobe = 1'b0;
        coef = 16'sd0;
        tick();
        tick();
    endtask

    task automatic set_cf_ramp();
        for (int k = 0; k < TAPS; k++) cf[k] = k + 1;
    endtask

    task automatic set_cf_all(input int v);
        for (int k = 0; k < TAPS; k++) cf[k] = v;
    endtask

    task automatic frame_expect(input string name, input int lit);
        int v0;
        v0 = vcnt;
        frame(TAPS, -1, 0, -1, 0);
        chk({name, "_out"}, int'(mac_out), lit);
        chk({name, "_model"}, exp_out, lit);
        chk({name, "_vcnt"}, vcnt - v0, 1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int v0;
        int o0;
        tick();
        tick();
        chk("reset_out", int'(mac_out), 0);
        chk("reset_valid", int'(mac_valid), 0);
        chk("reset_overrun", int'(overrun), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Coefficient sum with latency
        fill(1);
        set_cf_ramp();
        frame_expect("coef_sum", 66);
        chk("latency", valid_cyc - start_cyc, 11);

        // Extremes
        fill(-4); set_cf_all(-32768); frame_expect("ext_neg_neg", 1441792);
        fill(3);  set_cf_all(32767);  frame_expect("ext_pos_pos", 1081311);
        fill(-4); set_cf_all(32767);  frame_expect("ext_neg_pos", -1441748);

        // Mid-frame strobes: tap 4 deferred, tap 8 dropped
        fill(1);
        set_cf_all(1);
        v0 = vcnt;
        o0 = ocnt;
        frame(TAPS, 4, 2, 8, 3);
        chk("midstrobe_out", int'(mac_out), 11);
        chk("midstrobe_vcnt", vcnt - v0, 1);
        chk("midstrobe_overrun", ocnt - o0, 1);
        set_cf_all(0);
        cf[0] = 1;
        frame_expect("dly0_after_defer", 2);
        set_cf_all(1);
        frame_expect("dly_after_defer", 12);

        // Asynchronous reset mid-accumulation (after tap 5)
        for (int i = 0; i < 6; i++) begin
            en = 1'b1;
            coef = 16'sd1;
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_out", int'(mac_out), 0);
        chk("midreset_valid", int'(mac_valid), 0);
        chk("midreset_overrun", int'(overrun), 0);
        en = 1'b0;
        coef = 16'sd0;
        tick();
        rst = 1'b0;
        tick();
        chk("after_reset_model_out", exp_out, 0);
        fill(2);
        set_cf_ramp();
        frame_expect("post_reset", 132);

        // Abort after tap 6
        set_cf_all(5);
        v0 = vcnt;
        frame(7, -1, 0, -1, 0);
        chk("abort_vcnt", vcnt - v0, 0);
        chk("abort_hold_out", int'(mac_out), 132);
        set_cf_all(1);
        frame_expect("after_abort", 22);

        // Enable held for 15 cycles
        set_cf_ramp();
        v0 = vcnt;
        frame(15, -1, 0, -1, 0);
        chk("hold_vcnt", vcnt - v0, 1);
        chk("hold_out", int'(mac_out), 132);
        set_cf_all(1);
        frame_expect("after_hold", 22);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_mac_acc.md
# fir_mac_acc

Multiply-accumulate stage directly downstream of the FIR control FSM and the coefficient SpSram. Holds an 11-deep delay line of input samples, shifted on the 600 kHz sample strobe. While the FSM asserts the MAC enable, it multiplies each coefficient read from SRAM by the matching delayed sample and accumulates. After the last tap it presents one registered filter output with a single-cycle valid pulse.

## Interface

- DATA_W, 3, signed input sample width
- COEF_W, 16, signed coefficient width (SRAM read data)
- TAPS, 11, number of taps per output
- ACC_W, 24, signed accumulator/output width; must be ≥ DATA_W+COEF_W+ceil(log2(TAPS))

- iClk12M  in  1  12 MHz system clock, all state on rising edge
- iRst  in  1  reset, asynchronous, active-high
- iEnSample600k  in  1  one-cycle sample strobe
- iFirIn  in  DATA_W  signed input sample, captured on strobe
- iEnMAC  in  1  MAC enable from control FSM; high one cycle per coefficient
- iRdDtRam  in  COEF_W  signed coefficient from SRAM, valid whenever iEnMAC=1
- oMacOut  out  ACC_W  signed filter output, registered, held until next result
- oMacValid  out  1  one-cycle pulse when oMacOut updates
- oOverrun  out  1  one-cycle pulse when a sample strobe is dropped

## Operation

- Delay line rDly[0..TAPS-1], rDly[0] newest. A shift moves rDly[k] to rDly[k+1] and loads iFirIn into rDly[0].
- Tap counter rTap, 0..TAPS-1. Tap k uses iRdDtRam × rDly[k].
- Product: full signed DATA_W+COEF_W product, sign-extended to ACC_W. No saturation; ACC_W sizing makes overflow impossible.
- States:
  - p_Idle: rTap=0. On an iEnMAC=1 edge, rAcc ← product(tap 0), rTap ← 1, go to p_Acc. With TAPS=1, go straight to the completion path.
  - p_Acc: on an iEnMAC=1 edge, rAcc ← rAcc + product, rTap++. When the edge consumes tap TAPS-1:
    - oMacOut ← rAcc + product
    - oMacValid ← 1
    - rTap ← 0
    - go to p_Wait
  - p_Acc, iEnMAC=0 (abort): rAcc ← 0, rTap ← 0, go to p_Idle. No valid; oMacOut keeps its old value.
  - p_Wait: iEnMAC=1 edges are ignored. On iEnMAC=0, go to p_Idle.
- Sample strobe:
  - In p_Idle or p_Wait: shift immediately.
  - In p_Acc: set rShiftPend and do not shift, so all taps of one output use one snapshot. The pending shift executes on the first cycle the state is not p_Acc.
  - Strobe while rShiftPend=1 and still in p_Acc: strobe dropped, oOverrun pulses the next cycle, rShiftPend stays 1. Only the first pending sample's iFirIn value is kept, latched at its strobe.
  - Strobe in the same cycle the pending shift executes: apply the pending shift; the new strobe shifts on the following cycle (it re-arms rShiftPend). No drop.
- Reset (any time, including mid-accumulation) clears:
  - rDly to all 0, rAcc, rTap, rShiftPend
  - oMacOut to 0, oMacValid to 0, oOverrun to 0
  - state to p_Idle
  
  Reset has priority over every other event.

## Timing

- oMacValid is high in the cycle immediately after the edge that consumes the TAPS-th coefficient. oMacOut is valid in that same cycle.
- Total latency is TAPS cycles from the first iEnMAC edge to oMacValid high, for back-to-back enables.
- Gaps in iEnMAC within a frame are not allowed; a low cycle aborts the frame.
- The strobe-to-shift delay is 0 cycles when not accumulating. Otherwise the shift happens at most 1 cycle after the accumulation ends or aborts.
- At 12 MHz and 600 kHz there are 20 cycles per sample, and an 11-tap frame fits. Overrun indicates an upstream control fault.

## Test plan

- Reset: assert iRst asynchronously mid-p_Acc (tap 5) → all outputs 0 within the same cycle, state p_Idle; the next full frame produces a correct result.
- Coefficient sum: 11 strobes with iFirIn=1, then iEnMAC for 11 cycles with coef k = k+1 → oMacOut=66, oMacValid exactly one cycle, 11 cycles after the first enable.
- Extremes:
  - all rDly=-4 and all coef=-32768 → oMacOut=1441792
  - all rDly=3 and all coef=32767 → 1081311
  - rDly=-4 and coef=32767 → -1441748
- Mid-frame strobe:
  - iFirIn=2 strobe at tap 4 → the result uses the old snapshot; rDly[0]=2 appears one cycle after the final tap.
  - A second strobe at tap 8 → oOverrun pulses once, and only iFirIn from the first strobe enters the line.
- Abort and hold:
  - iEnMAC drops after tap 6 → no oMacValid, oMacOut unchanged; the next frame is correct.
  - iEnMAC held high for 15 cycles → exactly one valid pulse, and extra enables are ignored in p_Wait.
